// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO stream reader.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam int unsigned OCC_W = 2;

  // Beat-counter width; a single-beat frame still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer; entry 0 is always the head and drives the outputs.
module stream_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned PW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [PW-1:0]    s_data,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [PW-1:0]    m_data,
  output logic [OCC_W-1:0] occ
);

  logic [PW-1:0]    e0_q, e0_d, e1_q, e1_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             pop;

  assign m_valid = (occ_q != '0);
  assign m_data  = e0_q;
  assign occ     = occ_q;
  assign pop     = m_valid && m_ready;

  // Writer never pushes into a full buffer; upstream credit guarantees it.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case ({s_valid, pop})
      2'b10: begin
        if (occ_q == '0) e0_d = s_data;
        else             e1_d = s_data;
        occ_d = occ_q + OCC_W'(1);
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - OCC_W'(1);
      end
      2'b11: begin
        if (occ_q == OCC_W'(1)) begin
          e0_d = s_data;
        end else begin
          e0_d = e1_q;
          e1_d = s_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream with frame "last" markers.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic             fifo_wr_busy,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy
);

  localparam int unsigned        CNT_W     = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  rd_state_e        state_q;
  logic             inflight_q;
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
  logic [OCC_W-1:0] occ;
  logic             head_valid, hs, pop_acc, cap_last;
  logic [WIDTH:0]   head;

  assign hs = head_valid && m_ready;

  // A beat leaving this cycle frees the slot a new pop would need.
  assign fifo_rd_en = (state_q == ST_RUN) && en && !fifo_empty &&
                      (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, hs}));
  assign pop_acc    = fifo_rd_en && !fifo_wr_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (en) state_q <= ST_RUN;
        ST_RUN:   if (!en) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (en)                              state_q <= ST_RUN;
          else if (!inflight_q && occ == '0)   state_q <= ST_IDLE;
        end
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Frame position is tagged at capture; capture order equals delivery order.
  assign cap_last  = (cap_cnt_q == LAST_BEAT);
  assign cap_cnt_d = cap_last ? '0 : cap_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      cap_cnt_q  <= '0;
    end else begin
      inflight_q <= pop_acc;
      if (inflight_q) cap_cnt_q <= cap_cnt_d;
    end
  end

  stream_skid_buf #(.PW(WIDTH + 1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (inflight_q),
    .s_data  ({cap_last, fifo_rdata}),
    .m_ready (m_ready),
    .m_valid (head_valid),
    .m_data  (head),
    .occ     (occ)
  );

  assign m_valid = head_valid;
  assign m_data  = head[WIDTH-1:0];
  assign m_last  = head[WIDTH] && head_valid;
  assign busy    = inflight_q || (occ != '0);

endmodule
